// File: rtl/top_if.sv
// RTC front-panel interface: user buttons, IRQ request, and the multiplexed
// RTC address/data bus with its active-low strobes.
interface top_if;
  logic       IRQ;
  logic       Barriba;
  logic       Babajo;
  logic       Bderecha;
  logic       Bizquierda;
  logic       Bcentro;
  logic [7:0] Dir;
  logic [6:0] Punt;
  logic       CS;
  logic       RD;
  logic       WR;
  logic       AD;

  // Environment side: drives buttons/IRQ, observes the bus
  modport master (
    output IRQ, Barriba, Babajo, Bderecha, Bizquierda, Bcentro,
    input  Dir, Punt, CS, RD, WR, AD
  );

  // Controller side: consumes buttons/IRQ, drives the bus
  modport slave (
    input  IRQ, Barriba, Babajo, Bderecha, Bizquierda, Bcentro,
    output Dir, Punt, CS, RD, WR, AD
  );
endinterface

// File: rtl/top.sv
// RTC bus controller with clock/date/timer edit front panel.
// Runs a continuous read sweep over the RTC registers, issues pending edit
// writes at access boundaries and, when TOP_IRQ_SERVICE_EN is defined,
// acknowledges each IRQ rising edge with a write of 0x00 to 0xF1.
// Every access is 10 clocks: ADDR 3, GAP 2, DATA 3, END 2.
module top (
  input  logic CLK,
  input  logic RST,
  top_if.slave bus
);

  typedef enum logic [2:0] {ST_IDLE, ST_ADDR, ST_GAP, ST_DATA, ST_END} state_t;

  localparam int NFIELD = 7;

  // Field index -> RTC register address (sec, min, hour, day, month, year, timer)
  function automatic logic [7:0] field_addr(input logic [2:0] idx);
    case (idx)
      3'd0:    field_addr = 8'h21;
      3'd1:    field_addr = 8'h22;
      3'd2:    field_addr = 8'h23;
      3'd3:    field_addr = 8'h24;
      3'd4:    field_addr = 8'h25;
      3'd5:    field_addr = 8'h26;
      default: field_addr = 8'h41;
    endcase
  endfunction

  // Lowest legal BCD value of a field (day and month start at 01)
  function automatic logic [7:0] field_min(input logic [2:0] idx);
    field_min = (idx == 3'd3 || idx == 3'd4) ? 8'h01 : 8'h00;
  endfunction

  // Highest legal BCD value of a field
  function automatic logic [7:0] field_max(input logic [2:0] idx);
    case (idx)
      3'd0, 3'd1: field_max = 8'h59;
      3'd2:       field_max = 8'h23;
      3'd3:       field_max = 8'h31;
      3'd4:       field_max = 8'h12;
      default:    field_max = 8'h99;
    endcase
  endfunction

  // Sweep slot -> register address read in that slot
  function automatic logic [7:0] sweep_addr(input logic [3:0] idx);
    case (idx)
      4'd0:    sweep_addr = 8'h21;
      4'd1:    sweep_addr = 8'h22;
      4'd2:    sweep_addr = 8'h23;
      4'd3:    sweep_addr = 8'h24;
      4'd4:    sweep_addr = 8'h25;
      4'd5:    sweep_addr = 8'h26;
      4'd6:    sweep_addr = 8'h41;
      4'd7:    sweep_addr = 8'h42;
      4'd8:    sweep_addr = 8'h43;
      default: sweep_addr = 8'h44;
    endcase
  endfunction

  state_t     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [7:0] acc_addr_q, acc_addr_d;
  logic [7:0] acc_data_q, acc_data_d;
  logic       acc_wr_q, acc_wr_d;
  logic [3:0] sweep_q, sweep_d;
  logic       pend_valid_q, pend_valid_d;
  logic [7:0] pend_addr_q, pend_addr_d;
  logic [7:0] pend_data_q, pend_data_d;
  logic [4:0] btn_q, btn_d;      // {centro, izquierda, derecha, abajo, arriba}
  logic [6:0] punt_q, punt_d;
  logic [7:0] field_q [NFIELD];
  logic [7:0] field_d [NFIELD];

  logic       irq_pend;
  logic       take_irq;
  logic       take_pend;
  logic       start;

  logic [4:0] edge_v;
  logic [2:0] sel_idx;
  logic [7:0] sel_val;
  logic [7:0] inc_val;
  logic [7:0] dec_val;

`ifdef TOP_IRQ_SERVICE_EN
  logic irq_q, irq_d;
  logic irq_pend_q, irq_pend_d;

  // IRQ edge detection; a new edge re-arms service even as an old one is taken
  always_comb begin
    irq_d      = bus.IRQ;
    irq_pend_d = irq_pend_q;
    if (take_irq) irq_pend_d = 1'b0;
    if (bus.IRQ && !irq_q) irq_pend_d = 1'b1;
  end

  // IRQ sample and pending-service registers
  always_ff @(posedge CLK) begin
    if (!RST) begin
      irq_q      <= 1'b0;
      irq_pend_q <= 1'b0;
    end else begin
      irq_q      <= irq_d;
      irq_pend_q <= irq_pend_d;
    end
  end

  assign irq_pend = irq_pend_q;
`else
  logic unused_irq;
  logic unused_take_irq;
  assign unused_irq      = bus.IRQ;
  assign unused_take_irq = take_irq;
  assign irq_pend        = 1'b0;
`endif

  // Access sequencer: phase timing plus arbitration at each access boundary
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 2'd1;
    acc_addr_d = acc_addr_q;
    acc_data_d = acc_data_q;
    acc_wr_d   = acc_wr_q;
    sweep_d    = sweep_q;
    take_irq   = 1'b0;
    take_pend  = 1'b0;
    start      = 1'b0;
    case (state_q)
      ST_IDLE: start = 1'b1;
      ST_ADDR: if (cnt_q == 2'd2) begin state_d = ST_GAP;  cnt_d = 2'd0; end
      ST_GAP:  if (cnt_q == 2'd1) begin state_d = ST_DATA; cnt_d = 2'd0; end
      ST_DATA: if (cnt_q == 2'd2) begin state_d = ST_END;  cnt_d = 2'd0; end
      ST_END:  if (cnt_q == 2'd1) start = 1'b1;
      default: start = 1'b1;
    endcase
    if (start) begin
      state_d = ST_ADDR;
      cnt_d   = 2'd0;
      if (irq_pend) begin
        take_irq   = 1'b1;
        acc_addr_d = 8'hF1;
        acc_data_d = 8'h00;
        acc_wr_d   = 1'b1;
      end else if (pend_valid_q) begin
        take_pend  = 1'b1;
        acc_addr_d = pend_addr_q;
        acc_data_d = pend_data_q;
        acc_wr_d   = 1'b1;
      end else begin
        acc_addr_d = sweep_addr(sweep_q);
        acc_data_d = 8'h00;
        acc_wr_d   = 1'b0;
        sweep_d    = (sweep_q == 4'd9) ? 4'd0 : sweep_q + 4'd1;
      end
    end
  end

  // Bus strobes and multiplexed Dir decoded from the current phase
  always_comb begin
    bus.Dir = 8'h00;
    bus.CS  = 1'b1;
    bus.RD  = 1'b1;
    bus.WR  = 1'b1;
    bus.AD  = 1'b1;
    case (state_q)
      ST_ADDR: begin
        bus.Dir = acc_addr_q;
        bus.CS  = 1'b0;
        bus.AD  = 1'b0;
        bus.WR  = 1'b0;
      end
      ST_GAP: bus.Dir = acc_addr_q;
      ST_DATA: begin
        bus.CS = 1'b0;
        if (acc_wr_q) begin
          bus.WR  = 1'b0;
          bus.Dir = acc_data_q;
        end else begin
          bus.RD = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign bus.Punt = punt_q;

  // Button edges, field pointer movement, BCD edit and pending-write update
  always_comb begin
    btn_d  = {bus.Bcentro, bus.Bizquierda, bus.Bderecha, bus.Babajo, bus.Barriba};
    edge_v = btn_d & ~btn_q;

    sel_idx = 3'd0;
    for (int i = 0; i < NFIELD; i++) begin
      if (punt_q[i]) sel_idx = 3'(i);
    end
    sel_val = field_q[sel_idx];

    if (sel_val == field_max(sel_idx))  inc_val = field_min(sel_idx);
    else if (sel_val[3:0] == 4'd9)      inc_val = {sel_val[7:4] + 4'd1, 4'd0};
    else                                inc_val = {sel_val[7:4], sel_val[3:0] + 4'd1};

    if (sel_val == field_min(sel_idx))  dec_val = field_max(sel_idx);
    else if (sel_val[3:0] == 4'd0)      dec_val = {sel_val[7:4] - 4'd1, 4'd9};
    else                                dec_val = {sel_val[7:4], sel_val[3:0] - 4'd1};

    punt_d = punt_q;
    for (int i = 0; i < NFIELD; i++) field_d[i] = field_q[i];
    pend_valid_d = pend_valid_q & ~take_pend;
    pend_addr_d  = pend_addr_q;
    pend_data_d  = pend_data_q;

    if (!bus.Bcentro) begin
      punt_d = 7'd0;
    end else if (edge_v[4]) begin
      punt_d = 7'b0000001;
    end else if (punt_q != 7'd0) begin
      if (edge_v[0]) begin
        field_d[sel_idx] = inc_val;
        pend_valid_d     = 1'b1;
        pend_addr_d      = field_addr(sel_idx);
        pend_data_d      = inc_val;
      end else if (edge_v[1]) begin
        field_d[sel_idx] = dec_val;
        pend_valid_d     = 1'b1;
        pend_addr_d      = field_addr(sel_idx);
        pend_data_d      = dec_val;
      end else if (edge_v[2]) begin
        punt_d = {punt_q[5:0], punt_q[6]};
      end else if (edge_v[3]) begin
        punt_d = {punt_q[0], punt_q[6:1]};
      end
    end
  end

  // State registers; reset aborts any access in flight
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 2'd0;
      acc_addr_q   <= 8'h00;
      acc_data_q   <= 8'h00;
      acc_wr_q     <= 1'b0;
      sweep_q      <= 4'd0;
      pend_valid_q <= 1'b0;
      pend_addr_q  <= 8'h00;
      pend_data_q  <= 8'h00;
      btn_q        <= 5'd0;
      punt_q       <= 7'd0;
      for (int i = 0; i < NFIELD; i++) field_q[i] <= field_min(3'(i));
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      acc_addr_q   <= acc_addr_d;
      acc_data_q   <= acc_data_d;
      acc_wr_q     <= acc_wr_d;
      sweep_q      <= sweep_d;
      pend_valid_q <= pend_valid_d;
      pend_addr_q  <= pend_addr_d;
      pend_data_q  <= pend_data_d;
      btn_q        <= btn_d;
      punt_q       <= punt_d;
      for (int i = 0; i < NFIELD; i++) field_q[i] <= field_d[i];
    end
  end

endmodule

// File: tb/tb_top.sv
// Testbench for top: directed scenarios followed by randomized panel/IRQ/reset
// activity, every cycle compared against a transaction-level reference model.
module tb_top;
  logic CLK = 1'b0;
  logic RST = 1'b0;

  top_if bus ();

  top dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

`ifdef TOP_IRQ_SERVICE_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference model: decimal field values, selected field index, queued work
  int       f_min [7] = '{0, 0, 0, 1, 1, 0, 0};
  int       f_max [7] = '{59, 59, 23, 31, 12, 99, 99};
  bit [7:0] f_addr[7] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h41};
  bit [7:0] sw_addr[10] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26,
                            8'h41, 8'h42, 8'h43, 8'h44};
  int       m_val [7];
  int       m_sel = -1;
  bit       m_pend = 0;
  bit [7:0] m_pend_addr, m_pend_data;
  int       m_sweep = 0;
  bit       m_irqp = 0;
  bit       m_active = 0;
  int       m_k = 0;
  bit [7:0] m_addr, m_data;
  bit       m_wr;
  bit       p_up, p_dn, p_rt, p_lt, p_ce, p_irq;

  // Bus monitor state
  bit [7:0] cur_addr = 8'h00;
  bit       in_wdata = 0;
  int       wr_cnt = 0;
  bit [7:0] last_wr_addr = 8'h00, last_wr_data = 8'h00;
  int       f1_cnt = 0;
  int       f1_dir_cnt = 0;

  function automatic bit [7:0] to_bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  task automatic model_step();
    bit up, dn, rt, lt, ce, ir;
    up = bus.Barriba; dn = bus.Babajo; rt = bus.Bderecha;
    lt = bus.Bizquierda; ce = bus.Bcentro; ir = bus.IRQ;
    if (!RST) begin
      m_val = '{0, 0, 0, 1, 1, 0, 0};
      m_sel = -1; m_pend = 0; m_sweep = 0; m_irqp = 0; m_active = 0; m_k = 0;
      p_up = 0; p_dn = 0; p_rt = 0; p_lt = 0; p_ce = 0; p_irq = 0;
      return;
    end
    if (!m_active || m_k == 9) begin
      m_active = 1; m_k = 0;
      if (IRQ_EN && m_irqp) begin
        m_addr = 8'hF1; m_data = 8'h00; m_wr = 1; m_irqp = 0;
      end else if (m_pend) begin
        m_addr = m_pend_addr; m_data = m_pend_data; m_wr = 1; m_pend = 0;
      end else begin
        m_addr = sw_addr[m_sweep]; m_data = 8'h00; m_wr = 0;
        m_sweep = (m_sweep + 1) % 10;
      end
    end else begin
      m_k++;
    end
    if (IRQ_EN && ir && !p_irq) m_irqp = 1;
    if (!ce) begin
      m_sel = -1;
    end else if (!p_ce) begin
      m_sel = 0;
    end else if (m_sel >= 0) begin
      if (up && !p_up) begin
        m_val[m_sel] = (m_val[m_sel] == f_max[m_sel]) ? f_min[m_sel] : m_val[m_sel] + 1;
        m_pend = 1; m_pend_addr = f_addr[m_sel]; m_pend_data = to_bcd(m_val[m_sel]);
      end else if (dn && !p_dn) begin
        m_val[m_sel] = (m_val[m_sel] == f_min[m_sel]) ? f_max[m_sel] : m_val[m_sel] - 1;
        m_pend = 1; m_pend_addr = f_addr[m_sel]; m_pend_data = to_bcd(m_val[m_sel]);
      end else if (rt && !p_rt) begin
        m_sel = (m_sel + 1) % 7;
      end else if (lt && !p_lt) begin
        m_sel = (m_sel + 6) % 7;
      end
    end
    p_up = up; p_dn = dn; p_rt = rt; p_lt = lt; p_ce = ce; p_irq = ir;
  endtask

  task automatic monitor();
    bit wdata;
    if (!bus.CS && !bus.AD) cur_addr = bus.Dir;
    wdata = !bus.CS && bus.AD && !bus.WR;
    if (wdata && !in_wdata) begin
      wr_cnt++;
      last_wr_addr = cur_addr;
      last_wr_data = bus.Dir;
      if (cur_addr == 8'hF1) f1_cnt++;
    end
    in_wdata = wdata;
    if (bus.Dir == 8'hF1) f1_dir_cnt++;
  endtask

  task automatic check_outputs();
    logic [18:0] obs, expv;
    logic [7:0]  e_dir;
    logic [3:0]  e_str;   // {CS, RD, WR, AD}
    e_dir = 8'h00; e_str = 4'b1111;
    if (m_active) begin
      if (m_k < 3)      begin e_dir = m_addr; e_str = 4'b0100; end
      else if (m_k < 5) begin e_dir = m_addr; e_str = 4'b1111; end
      else if (m_k < 8) begin
        if (m_wr) begin e_dir = m_data; e_str = 4'b0101; end
        else      begin e_dir = 8'h00;  e_str = 4'b0011; end
      end
    end
    expv = {e_dir, (m_sel < 0) ? 7'd0 : 7'(1 << m_sel), e_str};
    obs  = {bus.Dir, bus.Punt, bus.CS, bus.RD, bus.WR, bus.AD};
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL bus_model cyc=%0d observed={Dir,Punt,CS,RD,WR,AD}=%h expected=%h", cyc, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    model_step();
    #1;
    cyc++;
    monitor();
    check_outputs();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic wait_write(input int budget, output bit found);
    int start_cnt;
    start_cnt = wr_cnt;
    found = 0;
    for (int i = 0; i < budget && !found; i++) begin
      tick();
      if (wr_cnt != start_cnt) found = 1;
    end
  endtask

  initial begin
    bit found;
    int base;
    bus.IRQ = 0; bus.Barriba = 0; bus.Babajo = 0; bus.Bderecha = 0;
    bus.Bizquierda = 0; bus.Bcentro = 0;
    RST = 0;
    repeat (3) tick();
    chk("rst_dir", 32'(bus.Dir), 32'h00);
    chk("rst_strobes", 32'({bus.CS, bus.RD, bus.WR, bus.AD}), 32'hF);
    chk("rst_punt", 32'(bus.Punt), 32'h0);

    // First read of 0x21 right after reset release
    RST = 1;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("first_addr_dir", 32'(bus.Dir), 32'h21);
      chk("first_addr_cs_ad_wr", 32'({bus.CS, bus.AD, bus.WR}), 32'h0);
      tick();
    end
    repeat (87) tick();
    chk("sweep_0x44_at_90", 32'(bus.Dir), 32'h44);
    chk("sweep_0x44_addr_phase", 32'({bus.CS, bus.AD}), 32'h0);

    // Enter edit and move the pointer right
    bus.Bcentro = 1; tick();
    chk("edit_enter_punt", 32'(bus.Punt), 32'h01);
    bus.Bderecha = 1; tick(); bus.Bderecha = 0;
    chk("rotate_right_punt", 32'(bus.Punt), 32'h02);
    found = 0;
    for (int i = 0; i < 110 && !found; i++) begin
      tick();
      if (bus.Dir == 8'h44) found = 1;
    end
    chk("sweep_continues_in_edit", 32'(found), 32'h1);

    // Hour 00 decrements to 23 and is written to 0x23
    bus.Bderecha = 1; tick(); bus.Bderecha = 0; tick();
    chk("punt_hour", 32'(bus.Punt), 32'h04);
    bus.Babajo = 1; tick(); bus.Babajo = 0;
    wait_write(40, found);
    chk("hour_write_seen", 32'(found), 32'h1);
    chk("hour_write_addr", 32'(last_wr_addr), 32'h23);
    chk("hour_write_data", 32'(last_wr_data), 32'h23);

    // Back to seconds, set 59, then simultaneous up+right wraps to 00 only
    bus.Bizquierda = 1; tick(); bus.Bizquierda = 0; tick();
    bus.Bizquierda = 1; tick(); bus.Bizquierda = 0; tick();
    chk("punt_sec", 32'(bus.Punt), 32'h01);
    bus.Babajo = 1; tick(); bus.Babajo = 0;
    wait_write(40, found);
    chk("sec59_write_addr", 32'(last_wr_addr), 32'h21);
    chk("sec59_write_data", 32'(last_wr_data), 32'h59);
    bus.Barriba = 1; bus.Bderecha = 1; tick(); bus.Barriba = 0; bus.Bderecha = 0;
    wait_write(40, found);
    chk("sec_wrap_write_addr", 32'(last_wr_addr), 32'h21);
    chk("sec_wrap_write_data", 32'(last_wr_data), 32'h00);
    chk("sec_wrap_punt_kept", 32'(bus.Punt), 32'h01);

    // IRQ behaviour in normal mode
    bus.Bcentro = 0; tick();
    chk("leave_edit_punt", 32'(bus.Punt), 32'h0);
`ifdef TOP_IRQ_SERVICE_EN
    base = f1_cnt;
    bus.IRQ = 1;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (f1_cnt != base) found = 1;
    end
    chk("irq_write_within_20", 32'(found), 32'h1);
    chk("irq_write_data", 32'(last_wr_data), 32'h00);
    repeat (60) tick();
    chk("irq_held_single", 32'(f1_cnt - base), 32'd1);
    bus.IRQ = 0; tick(); tick();
    bus.IRQ = 1;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (f1_cnt != base + 1) found = 1;
    end
    chk("irq_second_edge", 32'(f1_cnt - base), 32'd2);
    bus.IRQ = 0; tick();
`else
    base = f1_dir_cnt;
    for (int i = 0; i < 1000; i++) begin
      if (i % 37 == 0) bus.IRQ = ~bus.IRQ;
      tick();
    end
    bus.IRQ = 0;
    chk("irq_disabled_no_f1", 32'(f1_dir_cnt - base), 32'd0);
`endif

    // Randomized panel, IRQ and reset activity against the model
    for (int c = 0; c < 4000; c++) begin
      if (!RST) begin
        if ($urandom_range(3) == 0) RST = 1;
      end else if ($urandom_range(599) == 0) begin
        RST = 0;
      end
      bus.Barriba    = ($urandom_range(9) == 0);
      bus.Babajo     = ($urandom_range(9) == 0);
      bus.Bderecha   = ($urandom_range(9) == 0);
      bus.Bizquierda = ($urandom_range(9) == 0);
      if ($urandom_range(79) == 0) bus.Bcentro = ~bus.Bcentro;
      if ($urandom_range(29) == 0) bus.IRQ = ~bus.IRQ;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/top.md
TOP -- requirements
Module: top

Interface
REQ-001 CLK  input  1  system clock; all state changes on rising edge.
REQ-002 RST  input  1  reset, synchronous, active-low (RST=0 sampled on CLK rising edge resets all state).
REQ-003 IRQ  input  1  RTC interrupt request, active-high level.
REQ-004 Barriba, Babajo, Bderecha, Bizquierda  input  1 each  debounced buttons: increment, decrement, next field, previous field.
REQ-005 Bcentro  input  1  edit-mode level: 1 = edit, 0 = normal.
REQ-006 Dir  output  8  multiplexed RTC address/data bus value.
REQ-007 Punt  output  7  one-hot edit-field pointer; 0 outside edit mode.
REQ-008 CS, RD, WR, AD  output  1 each  RTC bus strobes, all active-low; AD=0 marks address phase.

Function
REQ-009 Internal BCD fields, each with fixed address and range: sec 0x21 00-59, min 0x22 00-59, hour 0x23 00-23, day 0x24 01-31, month 0x25 01-12, year 0x26 00-99, timer 0x41 00-99; Punt bit0..bit6 select them in that order.
REQ-010 Each bus access is exactly 10 clocks: ADDR 3 clk (CS=0, AD=0, WR=0, RD=1, Dir=address); GAP 2 clk (strobes high, Dir=address); DATA 3 clk (CS=0, AD=1; write: WR=0, Dir=data; read: RD=0, Dir=0x00); END 2 clk (strobes high, Dir=0x00).
REQ-011 Idle/between accesses: CS=RD=WR=AD=1, Dir=0x00.
REQ-012 Read sweep: back-to-back read accesses to 0x21-0x26, 0x41, 0x42, 0x43, 0x44, then restarts at 0x21; runs in both modes; read data is not captured by this block.
REQ-013 Arbitration only at access boundaries (END complete), priority IRQ service > pending edit write > next sweep read; a preempted sweep resumes at the address it would have issued next.
REQ-014 IRQ service: one write access to address 0xF1 with data 0x00 per IRQ rising edge (IRQ sampled into a register; edge = sampled 0->1); IRQ held high triggers no further service.
REQ-015 Buttons edge-detected internally; one action per 0->1 transition; simultaneous edges: priority Barriba > Babajo > Bderecha > Bizquierda, others in that cycle discarded.
REQ-016 Bcentro 0->1: enter edit, Punt=7'b0000001; Bcentro 0: Punt=0, arrow/up/down ignored.
REQ-017 Bderecha: Punt rotates left (bit6 wraps to bit0); Bizquierda: rotates right (bit0 wraps to bit6).
REQ-018 Barriba/Babajo: selected field +1/-1 in BCD, wrapping max->min and min->max; then one write access of the new value to that field's address is pended (single-entry; newer edit overwrites pending one).
REQ-019 Leaving edit mode mid-access completes the current access; a pending edit write is still issued.

Reset
REQ-020 During reset: CS=RD=WR=AD=1, Dir=0x00, Punt=0, fields sec/min/hour/year/timer=00, day/month=01, no pending write, IRQ/button edge registers cleared, sweep pointer=0x21.
REQ-021 Reset asserted mid-access aborts it immediately; first access (read 0x21) starts the clock after RST returns high.

Configuration
REQ-022 Macro TOP_IRQ_SERVICE_EN: defined -> REQ-014 behaviour; undefined -> IRQ ignored, address 0xF1 never driven, all else identical.

Verification
REQ-023 Reset release -> first ADDR phase next clock: Dir=0x21, CS=0, AD=0, WR=0 for 3 clk; Dir=0x44 appears 90 clk after sweep start.
REQ-024 Bcentro=1, one-clock Bderecha pulse -> Punt 0000001 -> 0000010; Dir=0x44 still reached within 110 clk.
REQ-025 Edit, Punt=bit2 (hour=00), Babajo pulse -> hour=23; next boundary write access: Dir=0x23 addr phase, then Dir=0x23 data with WR=0.
REQ-026 Normal mode, IRQ 0->1 and held -> exactly one write with Dir=0xF1 within 20 clk, Dir=0x00 in DATA; no second 0xF1 until IRQ falls and rises again.
REQ-027 Simultaneous Barriba and Bderecha edges in edit, sec=59 -> sec=00 written to 0x21, Punt unchanged.
REQ-028 TOP_IRQ_SERVICE_EN undefined, IRQ pulsed -> Dir never equals 0xF1 over 1000 clk.
